ntt_tf_addr_gen: RTL
====================

// Module: ntt_tf_addr_gen
// PURPOSE
//  Twiddle-factor address sequencer driving the per-path twiddle ROMs of the NTT/INTT core. On start it walks every
//  butterfly stage, issues one ROM address per cycle (shared by all paths), and delays a valid/stage/last sideband by
//  COMMON_BRAM_DELAY so the sideband lines up with the ROM read data at the butterfly input.
// PARAMETERS
//  ADDR_WIDTH         11  twiddle ROM address width; LOG_CYC = ADDR_WIDTH-1, cycles per stage CYC = 2**LOG_CYC
//  NUM_STAGE          11  stages per transform; legal range 1..ADDR_WIDTH
//  NTT_INTT_CASE      0   0: NTT, stages 0..NUM_STAGE-1; 1: INTT, stages NUM_STAGE-1 down to 0
//  COMMON_BRAM_DELAY  1   ROM read latency in cycles (>=1); sideband delay-line depth
//  STAGE_GAP          4   idle cycles between stages (butterfly pipeline drain); 0 legal
// PORTS
//  clk       in   1           clock
//  rst_n     in   1           async active-low reset
//  start     in   1           one-cycle pulse; sampled only in IDLE
//  stall     in   1           downstream back-pressure; holds the sequencer
//  busy      out  1           high from the cycle after start is accepted until done
//  rom_addr  out  ADDR_WIDTH  registered ROM address, to addra of every path ROM
//  addr_vld  out  1           rom_addr carries a real request this cycle
//  tf_vld    out  1           addr_vld delayed COMMON_BRAM_DELAY; ROM douta is valid
//  tf_stage  out  STG_W       stage of the current tf_vld word; STG_W = $clog2(NUM_STAGE)>0 ? $clog2(NUM_STAGE) : 1
//  tf_last   out  1           last word of a stage, aligned with tf_vld
//  done      out  1           one-cycle pulse after the final tf_vld
// BEHAVIOUR
//  Reset: every output is 0, FSM in IDLE, all counters and delay-line entries are 0.
//  FSM: IDLE -start-> RUN. RUN: j==CYC-1 with stall=0 -> GAP, or FLUSH if this is the final stage.
//   GAP: counts STAGE_GAP cycles, then RUN with next stage and j=0 (STAGE_GAP=0 goes straight to RUN).
//   FLUSH: waits COMMON_BRAM_DELAY cycles, then a 1-cycle DONE state pulses done; next cycle is IDLE.
//  Addressing: stage s, butterfly cycle j in [0,CYC-1]: rom_addr = (2**s - 1) + (j >> (LOG_CYC - s)).
//   Stage base and shift are computed combinationally from s. Max address 2**ADDR_WIDTH-2, so no overflow.
//  Timing: start accepted in cycle T gives the first addr_vld at T+1, and tf_vld for the same word at T+1+COMMON_BRAM_DELAY.
//  Stall: in RUN with stall=1, j and s hold and addr_vld=0. rom_addr keeps its last value.
//   Stall is ignored in GAP and FLUSH. The delay line always shifts because the ROM reads every cycle.
//  tf_stage/tf_last enter the delay line together with addr_vld; tf_last=1 only when j==CYC-1 with addr_vld=1.
//  Stall-free duration, start to done: NUM_STAGE*CYC + (NUM_STAGE-1)*STAGE_GAP + COMMON_BRAM_DELAY + 1 cycles.
//  start while busy is ignored with no side effects. start and the last cycle of FLUSH can coincide: start is ignored.
//  An rst_n assertion at any time returns the block to IDLE at once, clears the delay line and raises no done.
// CONFIGURATION
//  TF_STALL_CNT_EN defined: adds output stall_cnt[15:0] and a 16-bit saturating counter.
//   The counter counts RUN cycles with stall=1, clears when start is accepted, holds after done and resets to 0.
//  Undefined: the port and counter do not exist; behaviour is otherwise identical.
// STRUCTURE
//  ntt_intt_defines.vh: FSM state localparams (IDLE, RUN, GAP, FLUSH, DONE) and a function giving stage base (2**s-1).
//  Sub-module tf_sideband_delay: a COMMON_BRAM_DELAY-deep shift register carrying {vld, stage, last}.
//   It uses async reset and is reused by the butterfly data path.
//  Top level holds the FSM, the stage counter, j, the gap/flush counter and the address arithmetic.
// TESTING
//  Bench parameters: ADDR_WIDTH=4, NUM_STAGE=4, COMMON_BRAM_DELAY=2, STAGE_GAP=2, NTT.
//  1 Stall-free start: rom_addr sequence is stage0 0x8 zeros; stage1 1,1,1,1,2,2,2,2; stage2 3,3,4,4,5,5,6,6;
//    stage3 7..14. tf_vld count is 32 and done pulses 41 cycles after start.
//  2 stall=1 for 3 cycles in mid-stage 1 (j=5): addr_vld low 3 cycles, no skipped or repeated address, done 3 cycles later.
//  3 NTT_INTT_CASE=1: stage order is 3,2,1,0. The first address is 7, the last 8 addresses are 0.
//    tf_stage follows the same order.
//  4 start pulsed again at cycle 10 and at the FLUSH/IDLE boundary: no restart, exactly one done.
//  5 rst_n low during stage 2 for 1 cycle: all outputs 0 next cycle, no done, then a new start reproduces test 1 exactly.
//  6 With TF_STALL_CNT_EN and 5 stall cycles spread over RUN plus 3 stall cycles in GAP: stall_cnt==5 after done.

Source files
------------

// File: rtl/ntt_tf_addr_gen_pkg.sv
// Shared types for the twiddle address sequencer: FSM state encoding and stage base helper.
// Optional feature macro used elsewhere in the slice: TF_STALL_CNT_EN.
package ntt_tf_addr_gen_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_GAP   = 3'd2,
      ST_FLUSH = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Twiddles of stage s occupy a contiguous block starting at 2**s - 1.
   function automatic int unsigned stage_base(input int unsigned s);
      return (32'd1 << s) - 32'd1;
   endfunction

endpackage

// File: rtl/ntt_tf_addr_gen_if.sv
// Control and twiddle-sideband bundle between the sequencer (slave) and its controller/consumer (master).
interface ntt_tf_addr_gen_if #(
   parameter int ADDR_WIDTH = 11,
   parameter int STG_W      = 4
);
   import ntt_tf_addr_gen_pkg::*;

   // start is a one-cycle request taken only while busy=0; stall=1 holds the walk in RUN
   // (addr_vld drops that cycle); tf_vld/tf_stage/tf_last are qualified by tf_vld alone.
   logic                  start;
   logic                  stall;
   logic                  busy;
   logic [ADDR_WIDTH-1:0] rom_addr;
   logic                  addr_vld;
   logic                  tf_vld;
   logic [STG_W-1:0]      tf_stage;
   logic                  tf_last;
   logic                  done;
   state_t                dbg_state;

   modport slave (
      input  start, stall,
      output busy, rom_addr, addr_vld, tf_vld, tf_stage, tf_last, done, dbg_state
   );

   modport master (
      output start, stall,
      input  busy, rom_addr, addr_vld, tf_vld, tf_stage, tf_last, done, dbg_state
   );

endinterface

// File: rtl/ntt_tf_addr_gen_tf_sideband_delay.sv
// Fixed-depth shift register carrying {vld, stage, last} so it lines up with ROM/butterfly latency.
module tf_sideband_delay #(
   parameter int DEPTH = 1,
   parameter int STG_W = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_vld,
   input  logic [STG_W-1:0] in_stage,
   input  logic             in_last,
   output logic             out_vld,
   output logic [STG_W-1:0] out_stage,
   output logic             out_last
);
   localparam int W = STG_W + 2;

   logic [W-1:0] pipe [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= {in_vld, in_stage, in_last};
         for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign {out_vld, out_stage, out_last} = pipe[DEPTH-1];

endmodule

// File: rtl/ntt_tf_addr_gen.sv
// Twiddle ROM address sequencer: walks all NTT/INTT stages, one address per cycle, with aligned sideband.
// Define TF_STALL_CNT_EN to add the stall_cnt output (saturating count of stalled RUN cycles).
module ntt_tf_addr_gen
   import ntt_tf_addr_gen_pkg::*;
#(
   parameter int ADDR_WIDTH        = 11,
   parameter int NUM_STAGE         = 11,
   parameter int NTT_INTT_CASE     = 0,
   parameter int COMMON_BRAM_DELAY = 1,
   parameter int STAGE_GAP         = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   ntt_tf_addr_gen_if.slave    bus
`ifdef TF_STALL_CNT_EN
   ,
   output logic [15:0]         stall_cnt
`endif
);
   localparam int LOG_CYC = ADDR_WIDTH - 1;
   localparam int J_W     = (LOG_CYC > 0) ? LOG_CYC : 1;
   localparam int STG_W   = ($clog2(NUM_STAGE) > 0) ? $clog2(NUM_STAGE) : 1;
   localparam logic [J_W-1:0]   J_LAST = J_W'((1 << LOG_CYC) - 1);
   localparam logic [STG_W-1:0] K_LAST = STG_W'(NUM_STAGE - 1);

   state_t                state, state_n;
   logic [STG_W-1:0]      k, k_n;
   logic [J_W-1:0]        j, j_n;
   logic [15:0]           cnt, cnt_n;
   logic [ADDR_WIDTH-1:0] rom_addr_q, addr_nxt;
   int unsigned           sv, sh;
   logic                  issue, last_in;
   logic [STG_W-1:0]      stage_in;

   // k counts stages in walk order; INTT walks the physical stages in reverse.
   function automatic logic [STG_W-1:0] phys_stage(input logic [STG_W-1:0] kk);
      return (NTT_INTT_CASE != 0) ? (K_LAST - kk) : kk;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         k          <= '0;
         j          <= '0;
         cnt        <= '0;
         rom_addr_q <= '0;
      end else begin
         state <= state_n;
         k     <= k_n;
         j     <= j_n;
         cnt   <= cnt_n;
         if (state_n == ST_RUN) rom_addr_q <= addr_nxt;
      end
   end

   always_comb begin
      state_n = state;
      k_n     = k;
      j_n     = j;
      cnt_n   = cnt;
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               state_n = ST_RUN;
               k_n     = '0;
               j_n     = '0;
               cnt_n   = '0;
            end
         end
         ST_RUN: begin
            if (!bus.stall) begin
               if (j == J_LAST) begin
                  j_n = '0;
                  if (k == K_LAST) begin
                     state_n = ST_FLUSH;
                     cnt_n   = '0;
                  end else if (STAGE_GAP == 0) begin
                     k_n = k + 1'b1;
                  end else begin
                     state_n = ST_GAP;
                     cnt_n   = '0;
                  end
               end else begin
                  j_n = j + 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (int'(cnt) == STAGE_GAP - 1) begin
               state_n = ST_RUN;
               k_n     = k + 1'b1;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         ST_FLUSH: begin
            if (int'(cnt) == COMMON_BRAM_DELAY - 1) begin
               state_n = ST_DONE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // Address is registered from the next (stage, j) so it is ready the same cycle RUN presents it.
   always_comb begin
      sv       = 32'(phys_stage(k_n));
      sh       = 32'(LOG_CYC) - sv;
      addr_nxt = ADDR_WIDTH'(stage_base(sv) + (32'(j_n) >> sh));
   end

   assign issue    = (state == ST_RUN) && !bus.stall;
   assign last_in  = issue && (j == J_LAST);
   assign stage_in = issue ? phys_stage(k) : '0;

   tf_sideband_delay #(
      .DEPTH (COMMON_BRAM_DELAY),
      .STG_W (STG_W)
   ) u_sideband (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_vld    (issue),
      .in_stage  (stage_in),
      .in_last   (last_in),
      .out_vld   (bus.tf_vld),
      .out_stage (bus.tf_stage),
      .out_last  (bus.tf_last)
   );

   assign bus.rom_addr  = rom_addr_q;
   assign bus.addr_vld  = issue;
   assign bus.busy      = (state != ST_IDLE);
   assign bus.done      = (state == ST_DONE);
   assign bus.dbg_state = state;

`ifdef TF_STALL_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (state == ST_IDLE && bus.start) begin
         stall_cnt <= '0;
      end else if (state == ST_RUN && bus.stall && stall_cnt != 16'hFFFF) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule
